// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter - round-robin sharing of the memory data port between core (A) and host loader (B), rev 1.0
// Define ARB_STATS_EN to add saturating per-requester grant counters (gnt_cnt_a / gnt_cnt_b).
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt_a,
  output logic [CNT_W-1:0]  gnt_cnt_b
`endif
);

  logic last_b_q, last_b_d;
  logic rd_a_q, rd_a_d;
  logic rd_b_q, rd_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q <= 1'b1;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
    end
  end

  // On a tie the requester that was not served most recently wins.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      a_gnt = last_b_q;
      b_gnt = ~last_b_q;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt) begin
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
    end
    rd_a_d = a_gnt & ~a_we;
    rd_b_d = b_gnt & ~b_we;
  end

  always_comb begin
    mem_en    = a_gnt | b_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign a_stall  = a_req & ~a_gnt;
  assign a_rvalid = rd_a_q;
  assign b_rvalid = rd_b_q;
  assign a_rdata  = rd_a_q ? mem_rdata : '0;
  assign b_rdata  = rd_b_q ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (a_gnt && (cnt_a_q != '1)) begin
      cnt_a_d = cnt_a_q + CNT_ONE;
    end
    if (b_gnt && (cnt_b_q != '1)) begin
      cnt_b_d = cnt_b_q + CNT_ONE;
    end
  end

  assign gnt_cnt_a = cnt_a_q;
  assign gnt_cnt_b = cnt_b_q;
`else
  // CNT_W only sizes the statistics counters; still reject nonsense values.
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end
`endif

endmodule
`default_nettype wire
